// File: rtl/alu_pkg.sv
// Shared definitions for the 16-bit ALU datapath and its checker:
// widths, flag bit positions, result bundle and checker FSM encoding.
package alu_pkg;

    localparam int ALU_W = 16;

    // Bit positions inside the 6-bit mismatch mask
    localparam int SUM   = 5;
    localparam int SIGN  = 4;
    localparam int CARRY = 3;
    localparam int ZERO  = 2;
    localparam int OVF   = 1;
    localparam int PAR   = 0;

    typedef enum logic {
        RUN  = 1'b0,
        HALT = 1'b1
    } chk_state_e;

    typedef struct packed {
        logic [ALU_W-1:0] sum;
        logic             sign;
        logic             carry;
        logic             zero;
        logic             ovf;
        logic             par;
    } alu_res_t;

endpackage

// File: rtl/alu_ref_model.sv
// Combinational golden model of the ALU add path: sum plus the five
// status flags, computed from the two operands only.
module alu_ref_model
    import alu_pkg::*;
(
    input  logic [ALU_W-1:0] a,
    input  logic [ALU_W-1:0] b,
    output alu_res_t         res
);

    logic        [ALU_W:0]   ext_sum;
    logic signed [ALU_W-1:0] sa;
    logic signed [ALU_W-1:0] sb;
    logic signed [ALU_W-1:0] ssum;

    always_comb begin
        ext_sum = {1'b0, a} + {1'b0, b};
        sa      = signed'(a);
        sb      = signed'(b);
        ssum    = signed'(ext_sum[ALU_W-1:0]);

        res       = '0;
        res.sum   = ext_sum[ALU_W-1:0];
        res.carry = ext_sum[ALU_W];
        res.sign  = ssum[ALU_W-1];
        res.zero  = (ext_sum[ALU_W-1:0] == '0);
        // Two's-complement overflow: like-signed operands, result of other sign
        res.ovf   = (sa[ALU_W-1] == sb[ALU_W-1]) && (ssum[ALU_W-1] != sa[ALU_W-1]);
        res.par   = ~^ext_sum[ALU_W-1:0];
    end

endmodule

// File: rtl/alu_result_checker.sv
// In-circuit checker for the ALU add path: recomputes the expected result,
// flags mismatches, counts transactions/errors and captures the first failure.
module alu_result_checker
    import alu_pkg::*;
#(
    parameter bit STOP_ON_ERR = 1'b0,
    parameter int CNT_W       = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             clear,
    input  logic             in_valid,
    input  logic [15:0]      in_a,
    input  logic [15:0]      in_b,
    input  logic [15:0]      in_sum,
    input  logic             in_sign,
    input  logic             in_carry,
    input  logic             in_zero,
    input  logic             in_overflow,
    input  logic             in_parity,
    output logic             chk_valid,
    output logic             chk_pass,
    output logic [5:0]       err_mask,
    output logic [CNT_W-1:0] txn_count,
    output logic [CNT_W-1:0] err_count,
    output logic             first_err,
    output logic [15:0]      first_a,
    output logic [15:0]      first_b,
    output logic [15:0]      first_sum,
    output logic             halted
);

    function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
        return (&v) ? v : v + {{(CNT_W-1){1'b0}}, 1'b1};
    endfunction

    function automatic logic [5:0] compare(input alu_res_t obs, input alu_res_t exp);
        logic [5:0] m;
        m        = '0;
        m[SUM]   = (obs.sum != exp.sum);
        m[SIGN]  = obs.sign  ^ exp.sign;
        m[CARRY] = obs.carry ^ exp.carry;
        m[ZERO]  = obs.zero  ^ exp.zero;
        m[OVF]   = obs.ovf   ^ exp.ovf;
        m[PAR]   = obs.par   ^ exp.par;
        return m;
    endfunction

    chk_state_e state_q, state_d;

    logic             vld_p0, vld_p1;
    logic [ALU_W-1:0] a_p0, b_p0, a_p1, b_p1;
    alu_res_t         obs_p0, obs_p1, exp_p1;
    alu_res_t         exp_c;
    logic [5:0]       mask_c;
    logic             running, chk_fire, fail_c, halt_go;

    alu_ref_model u_ref (
        .a   (a_p0),
        .b   (b_p0),
        .res (exp_c)
    );

    always_comb begin
        running  = (state_q == RUN);
        mask_c   = compare(obs_p1, exp_p1);
        chk_fire = vld_p1 && running && !clear;
        fail_c   = chk_fire && (mask_c != '0);
        halt_go  = STOP_ON_ERR && fail_c;
    end

    // Stage p0: raw sample capture
    always_ff @(posedge clk) begin
        a_p0   <= in_a;
        b_p0   <= in_b;
        obs_p0 <= '{sum: in_sum, sign: in_sign, carry: in_carry,
                    zero: in_zero, ovf: in_overflow, par: in_parity};
    end

    // Stage p1: observed result alongside the golden result
    always_ff @(posedge clk) begin
        a_p1   <= a_p0;
        b_p1   <= b_p0;
        obs_p1 <= obs_p0;
        exp_p1 <= exp_c;
    end

    // Valids: entering HALT or clearing flushes everything in flight
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            vld_p0 <= 1'b0;
            vld_p1 <= 1'b0;
        end else begin
            vld_p0 <= in_valid && running && !clear && !halt_go;
            vld_p1 <= vld_p0 && running && !clear && !halt_go;
        end
    end

    // Stage p2: registered verdict, zeroed whenever no check is presented
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            chk_valid <= 1'b0;
            chk_pass  <= 1'b0;
            err_mask  <= '0;
        end else begin
            chk_valid <= chk_fire;
            chk_pass  <= chk_fire && (mask_c == '0);
            err_mask  <= chk_fire ? mask_c : 6'd0;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            txn_count <= '0;
            err_count <= '0;
        end else if (clear) begin
            txn_count <= '0;
            err_count <= '0;
        end else if (chk_fire) begin
            txn_count <= sat_inc(txn_count);
            if (fail_c)
                err_count <= sat_inc(err_count);
        end
    end

    // Only the earliest failure since reset/clear is kept
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            first_err <= 1'b0;
            first_a   <= '0;
            first_b   <= '0;
            first_sum <= '0;
        end else if (clear) begin
            first_err <= 1'b0;
            first_a   <= '0;
            first_b   <= '0;
            first_sum <= '0;
        end else if (fail_c && !first_err) begin
            first_err <= 1'b1;
            first_a   <= a_p1;
            first_b   <= b_p1;
            first_sum <= obs_p1.sum;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst)
            state_q <= RUN;
        else
            state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            RUN:     if (halt_go) state_d = HALT;
            HALT:    if (clear)   state_d = RUN;
            default: state_d = RUN;
        endcase
    end

    always_comb begin
        halted = (state_q == HALT);
    end

endmodule

// File: tb/tb_alu_result_checker.sv
// Directed bench for alu_result_checker: one free-running checker and one
// halting checker share the same stimulus.
module tb_alu_result_checker;

    logic        clk = 1'b0;
    logic        rst, clear, in_valid;
    logic [15:0] in_a, in_b, in_sum;
    logic        in_sign, in_carry, in_zero, in_overflow, in_parity;

    logic        chk_valid, chk_pass, first_err, halted;
    logic [5:0]  err_mask;
    logic [15:0] txn_count, err_count, first_a, first_b, first_sum;

    logic        h_chk_valid, h_chk_pass, h_first_err, h_halted;
    logic [5:0]  h_err_mask;
    logic [15:0] h_txn_count, h_err_count, h_first_a, h_first_b, h_first_sum;

    int n_pass = 0;
    int n_total = 0;

    always #5 clk = ~clk;

    alu_result_checker #(.STOP_ON_ERR(1'b0), .CNT_W(16)) u_dut (
        .clk(clk), .rst(rst), .clear(clear), .in_valid(in_valid),
        .in_a(in_a), .in_b(in_b), .in_sum(in_sum),
        .in_sign(in_sign), .in_carry(in_carry), .in_zero(in_zero),
        .in_overflow(in_overflow), .in_parity(in_parity),
        .chk_valid(chk_valid), .chk_pass(chk_pass), .err_mask(err_mask),
        .txn_count(txn_count), .err_count(err_count), .first_err(first_err),
        .first_a(first_a), .first_b(first_b), .first_sum(first_sum),
        .halted(halted)
    );

    alu_result_checker #(.STOP_ON_ERR(1'b1), .CNT_W(16)) u_halt (
        .clk(clk), .rst(rst), .clear(clear), .in_valid(in_valid),
        .in_a(in_a), .in_b(in_b), .in_sum(in_sum),
        .in_sign(in_sign), .in_carry(in_carry), .in_zero(in_zero),
        .in_overflow(in_overflow), .in_parity(in_parity),
        .chk_valid(h_chk_valid), .chk_pass(h_chk_pass), .err_mask(h_err_mask),
        .txn_count(h_txn_count), .err_count(h_err_count), .first_err(h_first_err),
        .first_a(h_first_a), .first_b(h_first_b), .first_sum(h_first_sum),
        .halted(h_halted)
    );

    // Present one sample for one cycle; flags are {sign,carry,zero,ovf,par}
    task automatic drive(input logic [15:0] a, input logic [15:0] b,
                         input logic [15:0] s, input logic [4:0] f);
        in_valid = 1'b1;
        in_a = a;
        in_b = b;
        in_sum = s;
        {in_sign, in_carry, in_zero, in_overflow, in_parity} = f;
        @(negedge clk);
    endtask

    task automatic idle(input int n);
        in_valid = 1'b0;
        repeat (n) @(negedge clk);
    endtask

    task automatic pulse_clear();
        in_valid = 1'b0;
        clear = 1'b1;
        @(negedge clk);
        clear = 1'b0;
    endtask

    task automatic test_reset();
        n_total++; if ({chk_valid, chk_pass, err_mask} !== 8'h00) $display("FAIL rst_verdict got %h want 00", {chk_valid, chk_pass, err_mask}); else n_pass++;
        n_total++; if ({txn_count, err_count} !== 32'h0) $display("FAIL rst_counts got %h want 0", {txn_count, err_count}); else n_pass++;
        n_total++; if ({first_err, first_a, first_b, first_sum} !== 49'h0) $display("FAIL rst_capture got %h want 0", {first_err, first_a, first_b, first_sum}); else n_pass++;
        n_total++; if ({halted, h_halted} !== 2'b00) $display("FAIL rst_halted got %b want 00", {halted, h_halted}); else n_pass++;
        rst = 1'b0;
        idle(2);
        n_total++; if (chk_valid !== 1'b0) $display("FAIL idle_valid got %b want 0", chk_valid); else n_pass++;
    endtask

    task automatic test_single_pass();
        drive(16'h0FFF, 16'h8000, 16'h8FFF, 5'b10000);
        idle(2);
        n_total++; if ({chk_valid, chk_pass} !== 2'b11) $display("FAIL single_pass got %b want 11", {chk_valid, chk_pass}); else n_pass++;
        n_total++; if (err_mask !== 6'b000000) $display("FAIL single_mask got %b want 000000", err_mask); else n_pass++;
        n_total++; if (txn_count !== 16'd1) $display("FAIL single_txn got %0d want 1", txn_count); else n_pass++;
        idle(1);
        n_total++; if ({chk_valid, chk_pass} !== 2'b00) $display("FAIL single_drop got %b want 00", {chk_valid, chk_pass}); else n_pass++;
    endtask

    task automatic test_back_to_back();
        drive(16'hFFFE, 16'h0002, 16'h0000, 5'b01101);
        drive(16'hAAAA, 16'h5555, 16'hFFFF, 5'b10001);
        idle(1);
        n_total++; if ({chk_valid, chk_pass, txn_count} !== {2'b11, 16'd2}) $display("FAIL b2b_first got %b/%0d want 11/2", {chk_valid, chk_pass}, txn_count); else n_pass++;
        idle(1);
        n_total++; if ({chk_valid, chk_pass, txn_count} !== {2'b11, 16'd3}) $display("FAIL b2b_second got %b/%0d want 11/3", {chk_valid, chk_pass}, txn_count); else n_pass++;
        n_total++; if (err_count !== 16'd0) $display("FAIL b2b_errs got %0d want 0", err_count); else n_pass++;
    endtask

    task automatic test_overflow_err();
        drive(16'h7FFF, 16'h0001, 16'h8000, 5'b10000);
        idle(2);
        n_total++; if ({chk_valid, chk_pass} !== 2'b10) $display("FAIL ovf_verdict got %b want 10", {chk_valid, chk_pass}); else n_pass++;
        n_total++; if (err_mask !== 6'b000010) $display("FAIL ovf_mask got %b want 000010", err_mask); else n_pass++;
        n_total++; if ({err_count, txn_count} !== {16'd1, 16'd4}) $display("FAIL ovf_counts got %0d/%0d want 1/4", err_count, txn_count); else n_pass++;
        n_total++; if ({first_err, first_a, first_b, first_sum} !== {1'b1, 16'h7FFF, 16'h0001, 16'h8000}) $display("FAIL ovf_capture got %b %h %h %h want 1 7fff 0001 8000", first_err, first_a, first_b, first_sum); else n_pass++;
    endtask

    task automatic test_consecutive_errs();
        pulse_clear();
        n_total++; if ({txn_count, err_count, first_err, first_a} !== 49'h0) $display("FAIL clear_state got %h want 0", {txn_count, err_count, first_err, first_a}); else n_pass++;
        drive(16'h0001, 16'h0001, 16'h0003, 5'b00000);
        drive(16'h0010, 16'h0020, 16'h0030, 5'b01001);
        idle(1);
        n_total++; if (err_mask !== 6'b100000) $display("FAIL b2b_err1_mask got %b want 100000", err_mask); else n_pass++;
        idle(1);
        n_total++; if (err_mask !== 6'b001000) $display("FAIL b2b_err2_mask got %b want 001000", err_mask); else n_pass++;
        n_total++; if ({err_count, txn_count} !== {16'd2, 16'd2}) $display("FAIL b2b_err_counts got %0d/%0d want 2/2", err_count, txn_count); else n_pass++;
        n_total++; if ({first_a, first_b, first_sum} !== {16'h0001, 16'h0001, 16'h0003}) $display("FAIL b2b_capture got %h %h %h want 0001 0001 0003", first_a, first_b, first_sum); else n_pass++;
    endtask

    task automatic test_clear_discard();
        logic seen;
        seen = 1'b0;
        clear = 1'b1;
        drive(16'h0001, 16'h0001, 16'h0002, 5'b00000);
        clear = 1'b0;
        in_valid = 1'b0;
        for (int i = 0; i < 4; i++) begin
            seen |= chk_valid;
            @(negedge clk);
        end
        n_total++; if ({seen, txn_count} !== 17'h0) $display("FAIL clear_discard got %b/%0d want 0/0", seen, txn_count); else n_pass++;
    endtask

    task automatic test_halt();
        logic seen;
        seen = 1'b0;
        pulse_clear();
        drive(16'h7FFF, 16'h0001, 16'h8000, 5'b10000);
        drive(16'h0001, 16'h0001, 16'h0002, 5'b00000);
        drive(16'h0001, 16'h0001, 16'h0002, 5'b00000);
        n_total++; if ({h_chk_valid, h_chk_pass, h_halted} !== 3'b101) $display("FAIL halt_enter got %b want 101", {h_chk_valid, h_chk_pass, h_halted}); else n_pass++;
        n_total++; if ({h_txn_count, h_err_count} !== {16'd1, 16'd1}) $display("FAIL halt_counts got %0d/%0d want 1/1", h_txn_count, h_err_count); else n_pass++;
        drive(16'h0001, 16'h0001, 16'h0002, 5'b00000);
        in_valid = 1'b0;
        for (int i = 0; i < 4; i++) begin
            seen |= h_chk_valid;
            @(negedge clk);
        end
        n_total++; if ({seen, h_halted, h_txn_count} !== {1'b0, 1'b1, 16'd1}) $display("FAIL halt_frozen got %b %b %0d want 0 1 1", seen, h_halted, h_txn_count); else n_pass++;
        n_total++; if (halted !== 1'b0) $display("FAIL nostop_halted got %b want 0", halted); else n_pass++;
        pulse_clear();
        n_total++; if ({h_halted, h_txn_count, h_err_count, h_first_err, h_first_a} !== 50'h0) $display("FAIL halt_clear got %h want 0", {h_halted, h_txn_count, h_err_count, h_first_err, h_first_a}); else n_pass++;
        drive(16'h0001, 16'h0001, 16'h0002, 5'b00000);
        idle(2);
        n_total++; if ({h_chk_valid, h_chk_pass, h_txn_count} !== {2'b11, 16'd1}) $display("FAIL halt_resume got %b/%0d want 11/1", {h_chk_valid, h_chk_pass}, h_txn_count); else n_pass++;
    endtask

    task automatic test_reset_midstream();
        logic seen;
        seen = 1'b0;
        drive(16'h0001, 16'h0001, 16'h0002, 5'b00000);
        rst = 1'b1;
        in_valid = 1'b0;
        #1;
        n_total++; if ({chk_valid, txn_count, h_txn_count, first_err} !== 34'h0) $display("FAIL rst_async got %h want 0", {chk_valid, txn_count, h_txn_count, first_err}); else n_pass++;
        @(negedge clk);
        rst = 1'b0;
        for (int i = 0; i < 4; i++) begin
            seen |= chk_valid | h_chk_valid;
            @(negedge clk);
        end
        n_total++; if ({seen, txn_count, err_mask} !== 23'h0) $display("FAIL rst_flush got %h want 0", {seen, txn_count, err_mask}); else n_pass++;
    endtask

    initial begin
        rst = 1'b1;
        clear = 1'b0;
        in_valid = 1'b0;
        in_a = '0;
        in_b = '0;
        in_sum = '0;
        {in_sign, in_carry, in_zero, in_overflow, in_parity} = '0;
        repeat (2) @(negedge clk);
        test_reset();
        test_single_pass();
        test_back_to_back();
        test_overflow_err();
        test_consecutive_errs();
        test_clear_discard();
        test_halt();
        test_reset_midstream();
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
